simt_mem_sequencer: RTL and testbench
=====================================

# simt_mem_sequencer

Serializes one warp-wide memory instruction (LDR/STR) from `tiny_gpu_core` onto a single shared memory port. It walks the active lanes in ascending thread order, issues one memory transaction per lane, collects the read data, and presents the whole warp's result in one response beat. It sits between the core's per-lane memory arrays and the single-ported data memory, and stalls the core until the instruction completes.

## Interface
Parameters:
- `NUM_THREADS`, 4: lanes per warp (≥1).
- `DATA_WIDTH`, 16: address and data width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `req_valid`  in  1: core presents a warp memory op.
- `req_ready`  out  1: sequencer accepts the op this cycle.
- `req_we`  in  1: 1 = STR, 0 = LDR.
- `req_mask`  in  NUM_THREADS: exec mask; bit t = lane t active.
- `req_addr`  in  [NUM_THREADS][DATA_WIDTH]: per-lane address.
- `req_wdata`  in  [NUM_THREADS][DATA_WIDTH]: per-lane store data.
- `resp_valid`  out  1: one-cycle pulse, warp op complete.
- `resp_rdata`  out  [NUM_THREADS][DATA_WIDTH]: per-lane load data; inactive lanes read 0.
- `busy`  out  1: op in flight (core stall).
- `mem_valid`  out  1: memory request.
- `mem_ready`  in  1: memory accepts the request.
- `mem_we`  out  1: write strobe.
- `mem_addr`  out  DATA_WIDTH: memory address.
- `mem_wdata`  out  DATA_WIDTH: memory write data.
- `mem_rvalid`  in  1: read data valid.
- `mem_rdata`  in  DATA_WIDTH: read data.

## Operation
- States: IDLE, ISSUE, WAIT_R, RESP.
- IDLE: `req_ready`=1. On `req_valid`, capture `req_we`, `req_mask`, `req_addr`, `req_wdata`, and clear the rdata buffer. If the mask is 0, go to RESP; otherwise set `lane` to the lowest set bit and go to ISSUE.
- ISSUE: drive `mem_valid`=1, `mem_addr`=addr[lane], `mem_we`=we, `mem_wdata`=wdata[lane]. These stay stable until `mem_ready`. On handshake:
  - Store: clear mask bit `lane`. If no bits remain, go to RESP; otherwise select the next lane and stay in ISSUE.
  - Load: go to WAIT_R.
- WAIT_R: on `mem_rvalid`, write rdata[lane]=`mem_rdata` and clear mask bit `lane`. Go to ISSUE if bits remain, else RESP. `mem_rvalid` arriving in any other state is ignored.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE. `resp_rdata` holds until the next accepted request.
- Lane order is strictly ascending. Each active lane gets exactly one transaction, even when addresses repeat (unless the Configuration feature is compiled in).
- `busy` = state != IDLE.

## Timing
- Reset (synchronous, `rst_n`=0 at a rising edge): state=IDLE. Outputs: `req_ready`=1, `busy`=0, `resp_valid`=0, `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `resp_rdata` all 0. Reset mid-op abandons the op with no response; an outstanding read return is ignored.
- Accept takes 1 cycle. The first `mem_valid` is asserted the cycle after acceptance.
- Zero-wait memory (`mem_ready`=1, `mem_rvalid` the cycle after handshake):
  - Store of k active lanes: `resp_valid` k+1 cycles after accept.
  - Load of k active lanes: `resp_valid` 2k+1 cycles after accept.
- Empty mask: `resp_valid` 1 cycle after accept.
- `req_ready`=0 outside IDLE. `req_valid` is ignored while busy.
- Outputs are registered, except `req_ready` and `busy`, which decode the state register.

## Configuration
- `SIMT_MEM_COALESCE_EN`:
  - Defined: during a load, when lane t's read returns, every still-pending active lane whose address equals addr[t] also receives that data and has its mask bit cleared in the same cycle.
  - Undefined: one transaction per active lane, always.
  - Stores are never coalesced.

## Structure
- Add to `gpu_isa_pkg`: `mem_seq_state_t` (IDLE, ISSUE, WAIT_R, RESP).
- Sub-module `simt_lane_select`: combinational lowest-set-bit finder. Takes a mask and returns `lane` (`$clog2(NUM_THREADS)` bits) plus `any`. It is reused in IDLE and after each lane retire.

## Test plan
- Load, mask 1111, mem returns addr+10, addr[t]=t, zero-wait: `mem_addr` sequence 0,1,2,3; `resp_rdata`={10,11,12,13}; `resp_valid` 9 cycles after accept.
- Store, mask 0101, wdata={5,6,7,8}, addr={20,21,22,23}: exactly two writes, (20,5) then (22,7); `resp_valid` 3 cycles after accept.
- Mask 0000: no `mem_valid`; `resp_valid` the next cycle; `resp_rdata` all 0.
- Backpressure: hold `mem_ready`=0 for 3 cycles on lane 2. `mem_addr`, `mem_wdata`, `mem_we` stay stable; `busy`=1 throughout; the response follows correctly.
- Reset asserted in WAIT_R: next cycle IDLE, `req_ready`=1, no `resp_valid`. A late `mem_rvalid` is ignored, and a subsequent load returns correct data.
- With `SIMT_MEM_COALESCE_EN`, load mask 1111, addr={4,4,9,4}: two reads (addr 4, then 9); `resp_rdata` lanes 0,1,3 are equal. Without the macro: four reads.

Source files
------------

// File: rtl/gpu_isa_pkg.sv
// Shared ISA-level types for the tiny GPU core: memory sequencer state
// encoding and a lane-index width helper.
package gpu_isa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } mem_seq_state_t;

  // Width of a lane index; a single-lane warp still needs one bit.
  function automatic int unsigned lane_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simt_lane_select.sv
// Combinational lowest-set-bit finder over a warp exec mask.
module simt_lane_select
  import gpu_isa_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned LANE_W      = lane_bits(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0] mask,
  output logic [LANE_W-1:0]      lane,
  output logic                   any
);

  always_comb begin
    lane = '0;
    any  = 1'b0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      if (mask[t] && !any) begin
        lane = LANE_W'(t);
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/simt_mem_sequencer.sv
// Serializes a warp-wide LDR/STR onto one shared memory port, lanes in
// ascending order. Define SIMT_MEM_COALESCE_EN to merge same-address loads.
module simt_mem_sequencer
  import gpu_isa_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned DATA_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [NUM_THREADS-1:0]                req_mask,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_addr,
  input  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_wdata,
  output logic                                  resp_valid,
  output logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] resp_rdata,
  output logic                                  busy,
  output logic                                  mem_valid,
  input  logic                                  mem_ready,
  output logic                                  mem_we,
  output logic [DATA_WIDTH-1:0]                 mem_addr,
  output logic [DATA_WIDTH-1:0]                 mem_wdata,
  input  logic                                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0]                 mem_rdata
);

  localparam int unsigned LANE_W = lane_bits(NUM_THREADS);

  mem_seq_state_t                         state_q, state_d;
  logic                                   we_q, we_d;
  logic [NUM_THREADS-1:0]                 mask_q, mask_d;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] addr_q, addr_d;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [LANE_W-1:0]                      lane_q, sel_lane;
  logic                                   sel_any;
  logic                                   mem_valid_q, mem_we_q, resp_valid_q;
  logic [DATA_WIDTH-1:0]                  mem_addr_q, mem_wdata_q;

  // Selector runs on the post-retire mask so the next lane is ready in one cycle.
  simt_lane_select #(
    .NUM_THREADS(NUM_THREADS),
    .LANE_W     (LANE_W)
  ) u_lane_select (
    .mask(mask_d),
    .lane(sel_lane),
    .any (sel_any)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          mask_d  = req_mask;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          state_d = (req_mask == '0) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          if (we_q) begin
            mask_d[lane_q] = 1'b0;
            state_d        = (mask_d == '0) ? RESP : ISSUE;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          rdata_d[lane_q] = mem_rdata;
          mask_d[lane_q]  = 1'b0;
`ifdef SIMT_MEM_COALESCE_EN
          for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            if (mask_q[t] && (addr_q[t] == addr_q[lane_q])) begin
              rdata_d[t] = mem_rdata;
              mask_d[t]  = 1'b0;
            end
          end
`endif
          state_d = (mask_d == '0) ? RESP : ISSUE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      lane_q       <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      lane_q       <= sel_lane;
      mem_valid_q  <= (state_d == ISSUE) && sel_any;
      resp_valid_q <= (state_d == RESP);
      // Memory request fields are reloaded only when the next beat is an issue.
      if (state_d == ISSUE) begin
        mem_we_q    <= we_d;
        mem_addr_q  <= addr_d[sel_lane];
        mem_wdata_q <= wdata_d[sel_lane];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign mem_valid  = mem_valid_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_simt_mem_sequencer.sv
// Self-checking bench for simt_mem_sequencer: directed vector table, reset and
// backpressure sequences, then randomized ops against a warp-level memory model.
module tb_simt_mem_sequencer;

  typedef logic [3:0][15:0] vec_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } tx_t;

  typedef struct {
    logic       we;
    logic [3:0] mask;
    vec_t       addr;
    vec_t       wdata;
    vec_t       exp_rd;
    int         exp_ntx;
    int         exp_lat;
  } vec_rec_t;

`ifdef SIMT_MEM_COALESCE_EN
  localparam int COAL = 1;
`else
  localparam int COAL = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_mask;
  vec_t        req_addr, req_wdata, resp_rdata;
  logic        resp_valid, busy;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  simt_mem_sequencer #(
    .NUM_THREADS(4),
    .DATA_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_mask  (req_mask),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .busy      (busy),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endfunction

  function automatic vec_t mk(input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v[0] = 16'(a0);
    v[1] = 16'(a1);
    v[2] = 16'(a2);
    v[3] = 16'(a3);
    return v;
  endfunction

  // Memory responder state and configuration
  logic [15:0] mem_arr [256];
  tx_t         log_q[$];
  int          rdy_pct, dly_min, dly_max;
  int          stall_left;
  logic [15:0] stall_addr, stall_wdata;
  bit          pend;
  int          pend_dly;
  logic [7:0]  pend_addr;

  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    pend       = 1'b0;
    pend_dly   = 0;
    pend_addr  = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (pend) begin
        if (pend_dly == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_arr[pend_addr];
          pend       = 1'b0;
        end else begin
          pend_dly--;
        end
      end
      if (mem_valid && stall_left > 0 && mem_addr == stall_addr) begin
        mem_ready = 1'b0;
        stall_left--;
        chk("stall_we", mem_we, 1);
        chk("stall_wdata", mem_wdata, stall_wdata);
        chk("stall_busy", busy, 1);
      end else begin
        mem_ready = ($urandom_range(99) < rdy_pct);
      end
      if (mem_valid && mem_ready && rst_n) begin
        log_q.push_back('{we: mem_we, addr: mem_addr, wdata: (mem_we ? mem_wdata : 16'h0)});
        if (mem_we) begin
          mem_arr[mem_addr[7:0]] = mem_wdata;
        end else begin
          pend      = 1'b1;
          pend_dly  = $urandom_range(dly_max, dly_min);
          pend_addr = mem_addr[7:0];
        end
      end
    end
  end

  // Warp-level reference: lane-ordered transaction list and final read data
  logic [15:0] ref_mem [256];
  tx_t         exp_q[$];
  vec_t        exp_rd;
  int          exp_lat;

  task automatic model_op(input logic we, input logic [3:0] mask, input vec_t addr, input vec_t wdata);
    bit dup;
    exp_q.delete();
    exp_rd = '0;
    for (int t = 0; t < 4; t++) begin
      if (mask[t]) begin
        if (we) begin
          exp_q.push_back('{we: 1'b1, addr: addr[t], wdata: wdata[t]});
          ref_mem[addr[t][7:0]] = wdata[t];
        end else begin
          dup = 1'b0;
          if (COAL != 0)
            for (int u = 0; u < t; u++)
              if (mask[u] && addr[u] == addr[t]) dup = 1'b1;
          if (!dup) exp_q.push_back('{we: 1'b0, addr: addr[t], wdata: 16'h0});
          exp_rd[t] = ref_mem[addr[t][7:0]];
        end
      end
    end
    exp_lat = we ? exp_q.size() + 1 : 2 * exp_q.size() + 1;
  endtask

  task automatic do_op(input logic we, input logic [3:0] mask, input vec_t addr, input vec_t wdata,
                       output vec_t rd, output int lat);
    chk("req_ready_idle", req_ready, 1);
    log_q.delete();
    req_valid = 1'b1;
    req_we    = we;
    req_mask  = mask;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = '1;
    req_wdata = '1;
    req_mask  = '1;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 200; i++) begin
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        break;
      end
      chk("busy_inflight", busy, 1);
      chk("not_ready_inflight", req_ready, 0);
      @(negedge clk);
    end
    if (lat == 0) begin
      failures++;
      $display("FAIL resp_timeout got=none exp=resp_valid within 200 cycles");
    end else begin
      chk("busy_in_resp", busy, 1);
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
      chk("idle_after_resp", req_ready, 1);
      chk("rdata_hold", resp_rdata, rd);
    end
  endtask

  task automatic check_op(input string tag, input vec_t rd, input int lat, input bit zero_wait);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_ntx"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk({tag, "_tx"}, log_q[i], exp_q[i]);
    if (zero_wait) chk({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  vec_rec_t tbl[8];
  vec_t     rd;
  int       lat;
  bit       found;
  logic     r_we;
  logic [3:0] r_mask;
  vec_t     r_addr, r_wdata;

  initial begin
    tbl[0] = '{1'b0, 4'b1111, mk(0, 1, 2, 3),     mk(0, 0, 0, 0), mk(10, 11, 12, 13), 4, 9};
    tbl[1] = '{1'b1, 4'b0101, mk(20, 21, 22, 23), mk(5, 6, 7, 8), mk(0, 0, 0, 0),     2, 3};
    tbl[2] = '{1'b0, 4'b0000, mk(1, 2, 3, 4),     mk(0, 0, 0, 0), mk(0, 0, 0, 0),     0, 1};
    tbl[3] = '{1'b0, 4'b0101, mk(20, 21, 22, 23), mk(0, 0, 0, 0), mk(5, 0, 7, 0),     2, 5};
    tbl[4] = '{1'b0, 4'b1111, mk(4, 4, 9, 4),     mk(0, 0, 0, 0), mk(14, 14, 19, 14),
               (COAL != 0) ? 2 : 4, (COAL != 0) ? 5 : 9};
    tbl[5] = '{1'b0, 4'b1000, mk(0, 0, 0, 30),    mk(0, 0, 0, 0), mk(0, 0, 0, 40),    1, 3};
    tbl[6] = '{1'b1, 4'b1111, mk(40, 40, 41, 42), mk(1, 2, 3, 4), mk(0, 0, 0, 0),     4, 5};
    tbl[7] = '{1'b0, 4'b0011, mk(40, 41, 0, 0),   mk(0, 0, 0, 0), mk(2, 3, 0, 0),     2, 5};

    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 16'(i + 10);
      ref_mem[i] = 16'(i + 10);
    end
    rdy_pct = 100; dly_min = 0; dly_max = 0;
    stall_left = 0; stall_addr = '0; stall_wdata = '0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mask = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);

    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      model_op(tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].wdata);
      do_op(tbl[i].we, tbl[i].mask, tbl[i].addr, tbl[i].wdata, rd, lat);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_ntx", i), log_q.size(), tbl[i].exp_ntx);
      check_op($sformatf("vec%0d", i), rd, lat, 1'b1);
    end

    // Backpressure on lane 2 of a store: three stalled cycles add three to latency
    stall_addr = 16'd32; stall_wdata = 16'h00C3; stall_left = 3;
    model_op(1'b1, 4'b0111, mk(30, 31, 32, 33), mk(16'hA1, 16'hB2, 16'hC3, 16'hD4));
    do_op(1'b1, 4'b0111, mk(30, 31, 32, 33), mk(16'hA1, 16'hB2, 16'hC3, 16'hD4), rd, lat);
    check_op("bp_store", rd, lat, 1'b0);
    chk("bp_lat", lat, 7);
    chk("bp_stalls_used", stall_left, 0);
    model_op(1'b0, 4'b0111, mk(30, 31, 32, 33), mk(0, 0, 0, 0));
    do_op(1'b0, 4'b0111, mk(30, 31, 32, 33), mk(0, 0, 0, 0), rd, lat);
    check_op("bp_load", rd, lat, 1'b1);
    chk("bp_load_rdata", rd, mk(16'hA1, 16'hB2, 16'hC3, 0));

    // Reset while waiting for read data; the late return must be dropped
    dly_min = 3; dly_max = 3;
    log_q.delete();
    req_valid = 1'b1; req_we = 1'b0; req_mask = 4'b0001; req_addr = mk(50, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (log_q.size() == 1 && !mem_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!found) begin
      failures++;
      $display("FAIL rstw_reach_wait got=no read issued exp=read in flight");
    end
    chk("rstw_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_req_ready", req_ready, 1);
    chk("rstw_busy_low", busy, 0);
    chk("rstw_mem_valid", mem_valid, 0);
    chk("rstw_mem_addr", mem_addr, 0);
    chk("rstw_rdata", resp_rdata, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rstw_no_resp", resp_valid, 0);
      chk("rstw_stay_idle", busy, 0);
      @(negedge clk);
    end
    dly_min = 0; dly_max = 0;
    model_op(1'b0, 4'b0011, mk(60, 61, 0, 0), mk(0, 0, 0, 0));
    do_op(1'b0, 4'b0011, mk(60, 61, 0, 0), mk(0, 0, 0, 0), rd, lat);
    check_op("rstw_load", rd, lat, 1'b1);
    chk("rstw_load_rdata", rd, mk(70, 71, 0, 0));

    // Random ops with random backpressure and read latency
    rdy_pct = 70; dly_min = 0; dly_max = 2;
    for (int n = 0; n < 40; n++) begin
      r_we   = 1'($urandom_range(1));
      r_mask = 4'($urandom);
      for (int t = 0; t < 4; t++) begin
        r_addr[t]  = 16'(100 + $urandom_range(7));
        r_wdata[t] = 16'($urandom);
      end
      model_op(r_we, r_mask, r_addr, r_wdata);
      do_op(r_we, r_mask, r_addr, r_wdata, rd, lat);
      check_op($sformatf("rand%0d", n), rd, lat, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
